// File: rtl/drac_pkg.sv
// drac_pkg: shared types and constants for the L2 refill path.
//   l2_arb_state_t   - refill arbiter FSM state (IDLE, ACQ, GRANT)
//   L2_ACQ_*         - fixed fields of the block acquire. These are driven at the
//                      top_drac level, next to the io_mem_acquire_* pins.
//   l2_refill_req_t  - one requester's view of a refill request
//   l2_refill_resp_t - one grant beat as seen by a requester
//   l2_xid           - maps a requester index onto the 2-bit client_xact_id
package drac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    GRANT = 2'd2
  } l2_arb_state_t;

  localparam logic        L2_ACQ_BUILTIN = 1'b1;
  localparam logic [2:0]  L2_ACQ_TYPE    = 3'b001;
  localparam logic [16:0] L2_ACQ_UNION   = 17'h001C1;
  localparam logic [1:0]  L2_ACQ_BEAT    = 2'd0;

  localparam int L2_ADDR_W = 26;
  localparam int L2_DATA_W = 128;

  typedef struct packed {
    logic                 valid;
    logic [L2_ADDR_W-1:0] paddr;
  } l2_refill_req_t;

  typedef struct packed {
    logic                 valid;
    logic [L2_DATA_W-1:0] data;
    logic [1:0]           beat;
    logic                 last;
  } l2_refill_resp_t;

  function automatic logic [1:0] l2_xid(input int unsigned idx);
    logic [31:0] v;
    v = idx;
    return v[1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req_i     - request vector
//   ptr_i     - index of the last winner; search starts at ptr_i+1
//   gnt_o     - one-hot grant (all zero when nothing requests)
//   gnt_idx_o - binary index of the granted requester
//   any_o     - at least one request present
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting just after the pointer and wrapping; the
  // first one found wins, so the last winner has the lowest priority.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/l2_refill_arbiter.sv
// l2_refill_arbiter: shares the single L2 acquire/grant port among N_REQ refill
// requesters (index 0 = icache). One block transaction is outstanding at a time:
// the arbiter picks a winner, issues the acquire, owns the 4-beat grant burst and
// routes each beat to the owner.
//
// Ports
//   CLK, RST             clock; asynchronous active-low reset
//   req_valid_i/paddr_i  per-requester block request and block address
//   req_ready_o          one-hot, request taken this cycle
//   req_kill_i           owner no longer wants its burst (beats are drained)
//   resp_*_o             beat forwarding to the owner (0-cycle latency)
//   mem_acquire_*        acquire channel to L2 (addr/xid latched at arbitration)
//   mem_grant_*          grant beat channel from L2 (never back-pressured)
//   busy_o               FSM not IDLE
//   err_timeout_o        sticky: burst not finished within TIMEOUT cycles
//   err_stray_o          sticky: beat outside GRANT or with an unexpected index
//   dbg_state_o          current FSM state
//
// Handshake: a transfer happens on a cycle where both valid and ready are 1.
// Requesters hold valid/paddr stable until ready (dropping early just loses
// arbitration). mem_acquire_valid_o stays up with stable addr/xid until
// mem_acquire_ready_i. Grant beats transfer whenever mem_grant_valid_i is 1.
module l2_refill_arbiter
  import drac_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_paddr_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ-1:0]        req_kill_i,
  output logic [N_REQ-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]       resp_data_o,
  output logic [1:0]              resp_beat_o,
  output logic                    resp_last_o,
  output logic                    mem_acquire_valid_o,
  input  logic                    mem_acquire_ready_i,
  output logic [ADDR_W-1:0]       mem_acquire_addr_o,
  output logic [1:0]              mem_acquire_xid_o,
  input  logic                    mem_grant_valid_i,
  input  logic [DATA_W-1:0]       mem_grant_data_i,
  input  logic [1:0]              mem_grant_beat_i,
  output logic                    mem_grant_ready_o,
  output logic                    busy_o,
  output logic                    err_timeout_o,
  output logic                    err_stray_o,
  output l2_arb_state_t           dbg_state_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  l2_arb_state_t     state_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        beat_cnt_q;
  logic [TMR_W-1:0]  timer_q;
  logic              drain_q;
  logic              err_timeout_q;
  logic              err_stray_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [ADDR_W-1:0] win_paddr;
  logic [N_REQ-1:0]  owner_oh;
  logic              in_burst;
  logic              kill_owner;
  logic              beat_fire;
  logic              beat_fwd;
  logic              last_beat;
  logic              stray_evt;
  logic              timeout_hit;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    win_paddr = '0;
    owner_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) win_paddr = req_paddr_i[i*ADDR_W +: ADDR_W];
      owner_oh[i] = (owner_q == IDX_W'(i));
    end
  end

  assign in_burst    = (state_q == ACQ) || (state_q == GRANT);
  // Only the owner's kill matters; other requesters have nothing in flight.
  assign kill_owner  = in_burst && (|(req_kill_i & owner_oh));
  assign beat_fire   = (state_q == GRANT) && mem_grant_valid_i;
  // A kill arriving with a beat suppresses that beat too.
  assign beat_fwd    = beat_fire && !drain_q && !kill_owner;
  // The burst ends on the fourth beat consumed, whatever index L2 reported.
  assign last_beat   = beat_fire && (beat_cnt_q == 2'd3);
  assign stray_evt   = mem_grant_valid_i &&
                       ((state_q != GRANT) || (mem_grant_beat_i != beat_cnt_q));
  assign timeout_hit = in_burst && (timer_q == TMR_LAST);

  assign req_ready_o         = (state_q == IDLE) ? arb_gnt : '0;
  assign resp_valid_o        = beat_fwd ? owner_oh : '0;
  assign resp_data_o         = beat_fwd ? mem_grant_data_i : '0;
  assign resp_beat_o         = beat_fwd ? mem_grant_beat_i : 2'd0;
  assign resp_last_o         = beat_fwd && (mem_grant_beat_i == 2'd3);
  assign mem_acquire_valid_o = (state_q == ACQ);
  assign mem_acquire_addr_o  = addr_q;
  assign mem_acquire_xid_o   = l2_xid(int'(owner_q));
  assign mem_grant_ready_o   = 1'b1;
  assign busy_o              = (state_q != IDLE);
  assign err_timeout_o       = err_timeout_q;
  assign err_stray_o         = err_stray_q;
  assign dbg_state_o         = state_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= IDX_W'(N_REQ - 1);
      addr_q        <= '0;
      beat_cnt_q    <= 2'd0;
      timer_q       <= '0;
      drain_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      if (stray_evt) err_stray_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (arb_any) begin
            addr_q     <= win_paddr;
            owner_q    <= arb_idx;
            rr_ptr_q   <= arb_idx;
            drain_q    <= 1'b0;
            timer_q    <= '0;
            beat_cnt_q <= 2'd0;
            state_q    <= ACQ;
          end
        end

        ACQ: begin
          if (kill_owner) drain_q <= 1'b1;
          if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else if (mem_acquire_ready_i) begin
            // Timer restarts at acceptance so the limit covers the burst itself.
            beat_cnt_q <= 2'd0;
            timer_q    <= '0;
            state_q    <= GRANT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        GRANT: begin
          if (kill_owner) drain_q <= 1'b1;
          if (last_beat) begin
            // A burst completing on the timeout cycle is not an error.
            beat_cnt_q <= 2'd0;
            drain_q    <= 1'b0;
            state_q    <= IDLE;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            drain_q       <= 1'b0;
            state_q       <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (beat_fire) beat_cnt_q <= beat_cnt_q + 2'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// Directed bench for l2_refill_arbiter (N_REQ=2, TIMEOUT=16).
module tb_l2_refill_arbiter;
  import drac_pkg::*;

  localparam int N  = 2;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int TO = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_paddr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_kill = '0;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic [1:0]      resp_beat;
  logic            resp_last;
  logic            acq_valid;
  logic            acq_ready = 1'b0;
  logic [AW-1:0]   acq_addr;
  logic [1:0]      acq_xid;
  logic            gv = 1'b0;
  logic [DW-1:0]   gdata = '0;
  logic [1:0]      gbeat = '0;
  logic            grant_ready;
  logic            busy;
  logic            err_timeout;
  logic            err_stray;
  l2_arb_state_t   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  l2_refill_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid_i(req_valid), .req_paddr_i(req_paddr), .req_ready_o(req_ready),
    .req_kill_i(req_kill),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_beat_o(resp_beat),
    .resp_last_o(resp_last),
    .mem_acquire_valid_o(acq_valid), .mem_acquire_ready_i(acq_ready),
    .mem_acquire_addr_o(acq_addr), .mem_acquire_xid_o(acq_xid),
    .mem_grant_valid_i(gv), .mem_grant_data_i(gdata), .mem_grant_beat_i(gbeat),
    .mem_grant_ready_o(grant_ready),
    .busy_o(busy), .err_timeout_o(err_timeout), .err_stray_o(err_stray),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    req_valid = '0; req_kill = '0; acq_ready = 1'b0;
    gv = 1'b0; gdata = '0; gbeat = 2'd0;
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    idle_inputs();
    tick(); tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic set_beat(input logic [1:0] b, input logic [DW-1:0] d);
    gv = 1'b1; gbeat = b; gdata = d;
  endtask

  task automatic clear_beat();
    gv = 1'b0; gbeat = 2'd0; gdata = '0;
  endtask

  // Requester already accepted: sit in ACQ one cycle, accept, land in GRANT.
  task automatic accept_acquire();
    acq_ready = 1'b1;
    tick();
    acq_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    tick();
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (acq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_acq_valid: got %b expected 0", acq_valid); end
    n_checks++; if (acq_addr !== '0 || acq_xid !== 2'd0) begin n_fail++; $display("FAIL reset_addr_xid: got %h/%0d expected 0/0", acq_addr, acq_xid); end
    n_checks++; if (resp_valid !== '0 || resp_last !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b/%b expected 00/0", resp_valid, resp_last); end
    n_checks++; if (err_timeout !== 1'b0 || err_stray !== 1'b0) begin n_fail++; $display("FAIL reset_errors: got %b%b expected 00", err_timeout, err_stray); end
    n_checks++; if (grant_ready !== 1'b1) begin n_fail++; $display("FAIL reset_grant_ready: got %b expected 1", grant_ready); end
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    req_paddr[0 +: AW] = 26'h12345;
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL basic_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    n_checks++; if (acq_valid !== 1'b1) begin n_fail++; $display("FAIL basic_acq_valid: got %b expected 1", acq_valid); end
    n_checks++; if (acq_addr !== 26'h12345) begin n_fail++; $display("FAIL basic_acq_addr: got %h expected 12345", acq_addr); end
    n_checks++; if (acq_xid !== 2'd0) begin n_fail++; $display("FAIL basic_acq_xid: got %0d expected 0", acq_xid); end
    accept_acquire();
    n_checks++; if (acq_valid !== 1'b0 || dbg_state !== GRANT) begin n_fail++; $display("FAIL basic_in_grant: got valid %b state %0d expected 0/%0d", acq_valid, dbg_state, GRANT); end
    for (int b = 0; b < 4; b++) begin
      d = 128'h0123_4567_89AB_CDEF_0000_0000_0000_0B00 + DW'(b);
      exp_q.push_back(d);
      set_beat(2'(b), d);
      #1;
      e = exp_q.pop_front();
      n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL basic_resp_valid b%0d: got %b expected 01", b, resp_valid); end
      n_checks++; if (resp_data !== e) begin n_fail++; $display("FAIL basic_resp_data b%0d: got %h expected %h", b, resp_data, e); end
      n_checks++; if (resp_beat !== 2'(b)) begin n_fail++; $display("FAIL basic_resp_beat b%0d: got %0d expected %0d", b, resp_beat, b); end
      n_checks++; if (resp_last !== (b == 3)) begin n_fail++; $display("FAIL basic_resp_last b%0d: got %b expected %b", b, resp_last, (b == 3)); end
      tick();
    end
    clear_beat();
    #1;
    n_checks++; if (dbg_state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL basic_back_idle: got state %0d busy %b expected %0d/0", dbg_state, busy, IDLE); end
    n_checks++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL basic_no_stray: got %b expected 0", err_stray); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] order [3];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;
    apply_reset();
    req_paddr[0 +: AW]  = 26'h0000AA;
    req_paddr[AW +: AW] = 26'h0000BB;
    req_valid = 2'b11;
    for (int t = 0; t < 3; t++) begin
      #1;
      n_checks++; if (req_ready !== order[t]) begin n_fail++; $display("FAIL b2b_ready t%0d: got %b expected %b", t, req_ready, order[t]); end
      tick();
      n_checks++; if (acq_xid !== ((t == 1) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL b2b_xid t%0d: got %0d expected %0d", t, acq_xid, (t == 1)); end
      n_checks++; if (acq_addr !== ((t == 1) ? 26'h0000BB : 26'h0000AA)) begin n_fail++; $display("FAIL b2b_addr t%0d: got %h", t, acq_addr); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL b2b_no_ready_acq t%0d: got %b expected 00", t, req_ready); end
      accept_acquire();
      for (int b = 0; b < 4; b++) begin
        set_beat(2'(b), DW'(32'hB2B0_0000 + t * 16 + b));
        #1;
        n_checks++; if (resp_valid !== order[t]) begin n_fail++; $display("FAIL b2b_resp t%0d b%0d: got %b expected %b", t, b, resp_valid, order[t]); end
        tick();
      end
      clear_beat();
    end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_acq_stall();
    // Last winner was req0, so req1 alone is taken immediately.
    req_paddr[AW +: AW] = 26'h2ABCDE;
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL stall_ready: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (acq_valid !== 1'b1) begin n_fail++; $display("FAIL stall_acq_valid c%0d: got %b expected 1", c, acq_valid); end
      n_checks++; if (acq_addr !== 26'h2ABCDE) begin n_fail++; $display("FAIL stall_addr c%0d: got %h expected 2abcde", c, acq_addr); end
      n_checks++; if (acq_xid !== 2'd1) begin n_fail++; $display("FAIL stall_xid c%0d: got %0d expected 1", c, acq_xid); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_no_ready c%0d: got %b expected 00", c, req_ready); end
      tick();
    end
    req_valid = 2'b00;
    accept_acquire();
    n_checks++; if (acq_valid !== 1'b0) begin n_fail++; $display("FAIL stall_acq_drop: got %b expected 0", acq_valid); end
    for (int b = 0; b < 4; b++) begin
      set_beat(2'(b), DW'(32'h5A11_0000 + b));
      #1;
      n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL stall_resp b%0d: got %b expected 10", b, resp_valid); end
      tick();
    end
    clear_beat();
    #1;
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL stall_idle: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_kill();
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    accept_acquire();
    set_beat(2'd0, DW'(32'h4B00));
    #1;
    n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL kill_beat0: got %b expected 10", resp_valid); end
    tick();
    set_beat(2'd1, DW'(32'h4B01));
    req_kill = 2'b01;  // non-owner: no effect
    #1;
    n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL kill_nonowner_beat1: got %b expected 10", resp_valid); end
    tick();
    clear_beat();
    req_kill = 2'b10;
    tick();
    req_kill = 2'b00;
    for (int b = 2; b < 4; b++) begin
      set_beat(2'(b), DW'(32'h4B00 + b));
      #1;
      n_checks++; if (resp_valid !== 2'b00 || resp_last !== 1'b0) begin n_fail++; $display("FAIL kill_drain b%0d: got %b/%b expected 00/0", b, resp_valid, resp_last); end
      tick();
    end
    clear_beat();
    #1;
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL kill_idle: got %0d expected %0d", dbg_state, IDLE); end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL kill_next_req0: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    accept_acquire();
    for (int b = 0; b < 4; b++) begin
      set_beat(2'(b), DW'(32'h4C00 + b));
      req_kill = (b == 0) ? 2'b01 : 2'b00;  // kill together with beat 0
      #1;
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL kill_same_cycle b%0d: got %b expected 00", b, resp_valid); end
      tick();
    end
    req_kill = 2'b00;
    clear_beat();
    #1;
    n_checks++; if (dbg_state !== IDLE || err_stray !== 1'b0) begin n_fail++; $display("FAIL kill_end: got state %0d stray %b expected %0d/0", dbg_state, err_stray, IDLE); end
  endtask

  task automatic test_stray();
    logic [1:0] seq [4];
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd2; seq[3] = 2'd3;
    apply_reset();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    accept_acquire();
    for (int b = 0; b < 4; b++) begin
      set_beat(seq[b], DW'(32'h57A0 + b));
      #1;
      n_checks++; if (resp_valid !== 2'b01 || resp_beat !== seq[b]) begin n_fail++; $display("FAIL stray_forward b%0d: got %b/%0d expected 01/%0d", b, resp_valid, resp_beat, seq[b]); end
      tick();
      if (b == 1) begin
        n_checks++; if (err_stray !== 1'b1) begin n_fail++; $display("FAIL stray_misorder: got %b expected 1", err_stray); end
      end
    end
    clear_beat();
    #1;
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL stray_misorder_idle: got %0d expected %0d", dbg_state, IDLE); end
    apply_reset();
    n_checks++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL stray_cleared: got %b expected 0", err_stray); end
    set_beat(2'd1, DW'(32'hDEAD));
    #1;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL stray_idle_dropped: got %b expected 00", resp_valid); end
    tick();
    clear_beat();
    #1;
    n_checks++; if (err_stray !== 1'b1 || dbg_state !== IDLE) begin n_fail++; $display("FAIL stray_idle_set: got %b state %0d expected 1/%0d", err_stray, dbg_state, IDLE); end
    tick(); tick(); tick();
    n_checks++; if (err_stray !== 1'b1) begin n_fail++; $display("FAIL stray_sticky: got %b expected 1", err_stray); end
  endtask

  task automatic test_timeout();
    apply_reset();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    accept_acquire();
    repeat (TO - 1) tick();
    n_checks++; if (err_timeout !== 1'b0 || dbg_state !== GRANT) begin n_fail++; $display("FAIL timeout_early: got %b state %0d expected 0/%0d", err_timeout, dbg_state, GRANT); end
    tick();
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b expected 1", err_timeout); end
    n_checks++; if (dbg_state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got %0d busy %b expected %0d/0", dbg_state, busy, IDLE); end
    set_beat(2'd0, DW'(32'h1A7E));
    #1;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL timeout_late_dropped: got %b expected 00", resp_valid); end
    tick();
    clear_beat();
    #1;
    n_checks++; if (err_stray !== 1'b1) begin n_fail++; $display("FAIL timeout_late_stray: got %b expected 1", err_stray); end
    tick(); tick();
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    accept_acquire();
    for (int b = 0; b < 2; b++) begin
      set_beat(2'(b), DW'(32'hA000 + b));
      tick();
    end
    set_beat(2'd2, DW'(32'hA002));
    RST = 1'b0;
    #1;
    n_checks++; if (resp_valid !== 2'b00 || resp_data !== '0 || resp_last !== 1'b0) begin n_fail++; $display("FAIL midrst_resp: got %b/%h/%b expected 00/0/0", resp_valid, resp_data, resp_last); end
    n_checks++; if (busy !== 1'b0 || acq_valid !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got busy %b acq %b state %0d", busy, acq_valid, dbg_state); end
    n_checks++; if (err_stray !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL midrst_errors: got %b%b expected 00", err_timeout, err_stray); end
    tick();
    clear_beat();
    RST = 1'b1;
    tick();
    req_paddr[AW +: AW] = 26'h3C0FFE;
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL midrst_new_ready: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (acq_addr !== 26'h3C0FFE || acq_xid !== 2'd1) begin n_fail++; $display("FAIL midrst_new_acq: got %h/%0d expected 3c0ffe/1", acq_addr, acq_xid); end
    accept_acquire();
    for (int b = 0; b < 4; b++) begin
      set_beat(2'(b), DW'(32'hF000 + b));
      #1;
      n_checks++; if (resp_valid !== 2'b10 || resp_last !== (b == 3)) begin n_fail++; $display("FAIL midrst_new_beat b%0d: got %b/%b expected 10/%b", b, resp_valid, resp_last, (b == 3)); end
      tick();
    end
    clear_beat();
    #1;
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_new_idle: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_acq_stall();
    test_kill();
    test_stray();
    test_timeout();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
